// File: rtl/ex_muldiv_unit_pkg.sv
// Shared constants and types for the RV32M iterative multiply/divide unit.
// Both the FSM and the iteration core import this package.
package ex_muldiv_unit_pkg;

  localparam int          XLEN_DEFAULT  = 32;
  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } m_func3_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } muldiv_state_e;

  function automatic logic opASigned(input logic [2:0] f);
    return (f == F3_MULH) || (f == F3_MULHSU) || (f == F3_DIV) || (f == F3_REM);
  endfunction

  function automatic logic opBSigned(input logic [2:0] f);
    return (f == F3_MULH) || (f == F3_DIV) || (f == F3_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_iter_core.sv
// Magnitude-only datapath: radix-2 shift-add multiply or restoring divide,
// one bit per step; {r_hi, r_lo} holds product, or remainder/quotient.
module muldiv_iter_core
  import ex_muldiv_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_step,
  input  logic              i_isDiv,
  input  logic [XLEN-1:0]   i_magA,
  input  logic [XLEN-1:0]   i_magB,
  output logic [2*XLEN-1:0] o_product,
  output logic [XLEN-1:0]   o_quotient,
  output logic [XLEN-1:0]   o_remainder,
  output logic              o_last
);

  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_b;
  logic [5:0]      r_count;

  logic [XLEN:0]   w_mulSum;
  logic [XLEN:0]   w_shifted;
  logic [XLEN:0]   w_diff;
  logic            w_qBit;

  always_comb begin
    w_mulSum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_shifted = {r_hi, r_lo[XLEN-1]};
    w_diff    = w_shifted - {1'b0, r_b};
    // No borrow means the shifted partial remainder covers the divisor.
    w_qBit    = ~w_diff[XLEN];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi    <= '0;
      r_lo    <= '0;
      r_b     <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_hi    <= '0;
      r_lo    <= i_magA;
      r_b     <= i_magB;
      r_count <= '0;
    end else if (i_step) begin
      if (i_isDiv) begin
        r_hi <= w_qBit ? w_diff[XLEN-1:0] : w_shifted[XLEN-1:0];
        r_lo <= {r_lo[XLEN-2:0], w_qBit};
      end else begin
        {r_hi, r_lo} <= {w_mulSum, r_lo[XLEN-1:1]};
      end
      if (!o_last) begin
        r_count <= r_count + 6'd1;
      end
    end
  end

  assign o_product   = {r_hi, r_lo};
  assign o_quotient  = r_lo;
  assign o_remainder = r_hi;
  assign o_last      = (r_count == 6'(XLEN-1));

endmodule

// File: rtl/ex_muldiv_unit.sv
// RV32M execute unit: FSM, operand sign handling, divide special cases and
// final sign fixup around the iterative magnitude core.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e   r_state;
  muldiv_state_e   w_nextState;
  logic [2:0]      r_func3;
  logic            r_negRes;
  logic            r_negRem;
  logic [XLEN-1:0] r_result;

  logic            w_accept;
  logic            w_signA;
  logic            w_signB;
  logic [XLEN-1:0] w_magA;
  logic [XLEN-1:0] w_magB;
  logic            w_divZero;
  logic            w_overflow;
  logic            w_special;
  logic [XLEN-1:0] w_specialVal;

  logic [2*XLEN-1:0] w_product;
  logic [2*XLEN-1:0] w_prodFix;
  logic [XLEN-1:0]   w_quotient;
  logic [XLEN-1:0]   w_remainder;
  logic [XLEN-1:0]   w_quotFix;
  logic [XLEN-1:0]   w_remFix;
  logic [XLEN-1:0]   w_fixVal;
  logic              w_last;
  logic              w_step;
  logic              w_isDiv;

  always_comb begin
    w_accept   = (r_state == ST_IDLE) && start && !flush;
    w_signA    = opASigned(func3) && op_a[XLEN-1];
    w_signB    = opBSigned(func3) && op_b[XLEN-1];
    w_magA     = w_signA ? -op_a : op_a;
    w_magB     = w_signB ? -op_b : op_b;
    w_divZero  = func3[2] && (op_b == '0);
    w_overflow = ((func3 == F3_DIV) || (func3 == F3_REM)) &&
                 (op_a == MIN_VAL) && (op_b == '1);
    w_special  = w_divZero || w_overflow;
    // func3[1] distinguishes REM/REMU from DIV/DIVU.
    if (w_divZero) begin
      w_specialVal = func3[1] ? op_a : DIV_BY_ZERO_Q;
    end else begin
      w_specialVal = func3[1] ? '0 : MIN_VAL;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_special) begin
            w_nextState = ST_DONE;
          end else if (func3[2]) begin
            w_nextState = ST_DIV;
          end else begin
            w_nextState = ST_MUL;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (w_last) begin
          w_nextState = ST_FIX;
        end
      end
      ST_FIX:  w_nextState = ST_DONE;
      ST_DONE: w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
    if (flush) begin
      w_nextState = ST_IDLE;
    end
  end

  assign stall = w_accept ||
                 (!flush && ((r_state == ST_MUL) || (r_state == ST_DIV) || (r_state == ST_FIX)));
  assign result_valid = (r_state == ST_DONE) && !flush;
  assign result       = r_result;

  assign w_step  = (r_state == ST_MUL) || (r_state == ST_DIV);
  assign w_isDiv = (r_state == ST_DIV);

  muldiv_iter_core #(
    .XLEN(XLEN)
  ) u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_accept && !w_special),
    .i_step      (w_step),
    .i_isDiv     (w_isDiv),
    .i_magA      (w_magA),
    .i_magB      (w_magB),
    .o_product   (w_product),
    .o_quotient  (w_quotient),
    .o_remainder (w_remainder),
    .o_last      (w_last)
  );

  // Quotient and product share the sign rule; remainder follows the dividend.
  always_comb begin
    w_prodFix = r_negRes ? -w_product : w_product;
    w_quotFix = r_negRes ? -w_quotient : w_quotient;
    w_remFix  = r_negRem ? -w_remainder : w_remainder;
    case (r_func3)
      F3_MUL:                       w_fixVal = w_prodFix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: w_fixVal = w_prodFix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              w_fixVal = w_quotFix;
      default:                      w_fixVal = w_remFix;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_func3  <= '0;
      r_negRes <= 1'b0;
      r_negRem <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_func3  <= func3;
        r_negRes <= w_signA ^ w_signB;
        r_negRem <= w_signA;
        if (w_special) begin
          r_result <= w_specialVal;
        end
      end else if ((r_state == ST_FIX) && !flush) begin
        r_result <= w_fixVal;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed-vector bench for ex_muldiv_unit: result values, strobe latency,
// stall shape, flush abort and asynchronous reset abort.
module tb_ex_muldiv_unit;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  func3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        stall;
  logic        result_valid;
  logic [31:0] result;

  int compareCount;
  int mismatchCount;

  ex_muldiv_unit #(
    .XLEN(32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .func3        (func3),
    .op_a         (op_a),
    .op_b         (op_b),
    .flush        (flush),
    .stall        (stall),
    .result_valid (result_valid),
    .result       (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic s, input logic [2:0] f,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic fl);
    start = s;
    func3 = f;
    op_a  = a;
    op_b  = b;
    flush = fl;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Holds start high through the DONE cycle, then drops it; entered and left at posedge+1.
  task automatic runOp(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expVal, input int expLat);
    int          firstValid;
    int          strobes;
    int          stallErrs;
    logic [31:0] got;
    firstValid = -1;
    strobes    = 0;
    stallErrs  = 0;
    got        = '0;
    for (int cyc = 0; cyc <= expLat + 2; cyc++) begin
      applyStimulus(cyc <= expLat, f, a, b, 1'b0);
      #1;
      if (result_valid === 1'b1) begin
        if (firstValid < 0) begin
          firstValid = cyc;
          got        = result;
        end
        strobes++;
      end
      if ((cyc < expLat) !== (stall === 1'b1)) begin
        stallErrs++;
      end
      nextCycle();
    end
    checkOutput({tag, "_result"}, got, expVal);
    checkOutput({tag, "_latency"}, 32'(firstValid), 32'(expLat));
    checkOutput({tag, "_strobes"}, 32'(strobes), 32'd1);
    checkOutput({tag, "_stallErrs"}, 32'(stallErrs), 32'd0);
  endtask

  initial begin
    int strobes;
    int stallErrs;
    compareCount  = 0;
    mismatchCount = 0;
    rst_n = 1'b0;
    applyStimulus(1'b0, F_MUL, 32'd0, 32'd0, 1'b0);
    nextCycle();
    checkOutput("reset_stall", {31'd0, stall}, 32'd0);
    checkOutput("reset_valid", {31'd0, result_valid}, 32'd0);
    checkOutput("reset_result", result, 32'd0);
    rst_n = 1'b1;
    nextCycle();

    runOp("mul_7_m3",      F_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    runOp("mulh_min_min",  F_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34);
    runOp("mulhu_max",     F_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    runOp("mulhsu_m1_2",   F_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 34);
    runOp("divu_100_7",    F_DIVU,   32'd100,        32'd7,         32'd14,        34);
    runOp("remu_100_7",    F_REMU,   32'd100,        32'd7,         32'd2,         34);
    runOp("div_m7_2",      F_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34);
    runOp("rem_m7_2",      F_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34);
    runOp("div_5_0",       F_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1);
    runOp("rem_5_0",       F_REM,    32'd5,          32'd0,         32'd5,         1);
    runOp("div_ovf",       F_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
    runOp("rem_ovf",       F_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);

    // Flush a divide in cycle 10, idle in cycle 11, new MUL from cycle 12.
    strobes   = 0;
    stallErrs = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      applyStimulus(1'b1, F_DIVU, 32'd100, 32'd7, 1'b0);
      #1;
      if (result_valid === 1'b1) strobes++;
      if (stall !== 1'b1) stallErrs++;
      nextCycle();
    end
    applyStimulus(1'b1, F_DIVU, 32'd100, 32'd7, 1'b1);
    #1;
    checkOutput("flush_stall_c10", {31'd0, stall}, 32'd0);
    checkOutput("flush_valid_c10", {31'd0, result_valid}, 32'd0);
    nextCycle();
    applyStimulus(1'b0, F_DIVU, 32'd100, 32'd7, 1'b0);
    #1;
    checkOutput("flush_stall_c11", {31'd0, stall}, 32'd0);
    if (result_valid === 1'b1) strobes++;
    checkOutput("flush_strobes", 32'(strobes), 32'd0);
    checkOutput("flush_pre_stall", 32'(stallErrs), 32'd0);
    nextCycle();
    runOp("mul_after_flush", F_MUL, 32'd1000, 32'd3000, 32'd3000000, 34);

    // Asynchronous reset in cycle 20 of a MUL.
    for (int cyc = 0; cyc < 20; cyc++) begin
      applyStimulus(1'b1, F_MUL, 32'd7, 32'hFFFF_FFFD, 1'b0);
      nextCycle();
    end
    applyStimulus(1'b0, F_MUL, 32'd7, 32'hFFFF_FFFD, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_stall", {31'd0, stall}, 32'd0);
    checkOutput("rst_mid_valid", {31'd0, result_valid}, 32'd0);
    checkOutput("rst_mid_result", result, 32'd0);
    #2;
    rst_n = 1'b1;
    nextCycle();
    checkOutput("rst_after_stall", {31'd0, stall}, 32'd0);
    checkOutput("rst_after_valid", {31'd0, result_valid}, 32'd0);
    runOp("div_after_reset", F_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 34);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
